satrnd_arbiter: RTL and testbench

Shares one pipelined saturation/rounding datapath between NREQ requesters. Each requester supplies a WIDTH-bit word plus its own tc/sat/rnd mode bits. Requests are granted round-robin, and each word is reduced to bits [MSB_OUT:LSB_OUT] with optional rounding and saturation. Results return on a single valid/ready output tagged with the requester ID. Per-requester saturating overflow counters feed the status registers.

---
 rtl/satrnd_arbiter.sv | 179 +++++++++++++++++
 tb/tb_satrnd_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/satrnd_arbiter.sv
// satrnd_arbiter: round-robin arbiter in front of a shared two-stage
// saturation/rounding pipeline with per-requester overflow counters.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_valid   - per-requester request valid
//   req_ready   - per-requester accept (one-hot or zero, combinational)
//   req_data    - packed request words, requester i at [i*WIDTH +: WIDTH]
//   req_tc      - per-requester 1 = two's complement, 0 = unsigned
//   req_sat     - per-requester saturate on overflow
//   req_rnd     - per-requester round half up (else truncate)
//   rsp_valid   - result valid
//   rsp_ready   - downstream accepts result
//   rsp_id      - requester index of result
//   rsp_data    - reduced result field [MSB_OUT:LSB_OUT]
//   rsp_ov      - overflow flag of result
//   ov_cnt      - packed saturating overflow counters, one per requester
//   cnt_clr     - synchronous clear of all overflow counters
module satrnd_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MSB_OUT = 14,
  parameter int unsigned LSB_OUT = 4,
  parameter int unsigned OVCNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*WIDTH-1:0]         req_data,
  input  logic [NREQ-1:0]               req_tc,
  input  logic [NREQ-1:0]               req_sat,
  input  logic [NREQ-1:0]               req_rnd,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NREQ)-1:0]       rsp_id,
  output logic [MSB_OUT-LSB_OUT:0]      rsp_data,
  output logic                          rsp_ov,
  output logic [NREQ*OVCNT_W-1:0]       ov_cnt,
  input  logic                          cnt_clr
);

  localparam int unsigned OUT_W = MSB_OUT - LSB_OUT + 1;
  localparam int unsigned IDW   = $clog2(NREQ);
  localparam int unsigned CW    = IDW + 1;
  // Two guard bits keep the rounded value exact for both signed and unsigned inputs.
  localparam int unsigned EXT   = WIDTH + 2;

  localparam logic signed [EXT-1:0] TC_MAX = EXT'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [EXT-1:0] TC_MIN = ~TC_MAX;
  localparam logic signed [EXT-1:0] U_MAX  = EXT'((64'd1 << OUT_W) - 64'd1);

  // Capture stage
  logic             s1_v;
  logic [WIDTH-1:0] s1_data;
  logic             s1_tc;
  logic             s1_sat;
  logic             s1_rnd;
  logic [IDW-1:0]   s1_id;

  logic [IDW-1:0]   ptr;
  logic [OVCNT_W-1:0] cnt [NREQ];

  logic             s2_load;
  logic             s1_can;
  logic             found;
  logic [IDW-1:0]   gnt_id;
  logic [CW-1:0]    cand;
  logic             accept;
  logic [IDW-1:0]   next_ptr;

  logic signed [EXT-1:0] din_x;
  logic signed [EXT-1:0] q;
  logic signed [EXT-1:0] r;
  logic                  rbit;
  logic                  ov;
  logic [OUT_W-1:0]      res;

  // Pipeline flow control: S2 refills when empty or draining, S1 follows S2.
  assign s2_load = !rsp_valid || rsp_ready;
  assign s1_can  = !s1_v || s2_load;

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found  = 1'b1;
        gnt_id = cand[IDW-1:0];
      end
    end
  end

  assign accept    = found && s1_can;
  assign req_ready = {NREQ{accept & rst_n}} & (NREQ'(1) << gnt_id);
  assign next_ptr  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

  // Rounding increment only exists when bits are dropped below the field.
  if (LSB_OUT > 0) begin : g_rnd
    assign rbit = s1_rnd & s1_data[LSB_OUT-1];
  end else begin : g_trunc
    assign rbit = 1'b0;
  end

  // Shift, round, overflow detect and saturate from the S1 registers.
  always_comb begin
    din_x = s1_tc ? $signed({{2{s1_data[WIDTH-1]}}, s1_data})
                  : $signed({2'b00, s1_data});
    q     = din_x >>> LSB_OUT;
    r     = q + $signed({{(EXT-1){1'b0}}, rbit});
    if (s1_tc) ov = (r < TC_MIN) || (r > TC_MAX);
    else       ov = (r > U_MAX);
    res = r[OUT_W-1:0];
    if (ov && s1_sat) begin
      if (s1_tc) res = s1_data[WIDTH-1] ? TC_MIN[OUT_W-1:0] : TC_MAX[OUT_W-1:0];
      else       res = '1;
    end
  end

  // Arbitration pointer and capture stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_tc   <= 1'b0;
      s1_sat  <= 1'b0;
      s1_rnd  <= 1'b0;
      s1_id   <= '0;
    end else if (accept) begin
      ptr     <= next_ptr;
      s1_v    <= 1'b1;
      s1_data <= req_data[32'(gnt_id) * WIDTH +: WIDTH];
      s1_tc   <= req_tc[gnt_id];
      s1_sat  <= req_sat[gnt_id];
      s1_rnd  <= req_rnd[gnt_id];
      s1_id   <= gnt_id;
    end else if (s2_load) begin
      s1_v    <= 1'b0;
    end
  end

  // Output stage; payload only updates when a real result moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_ov    <= 1'b0;
    end else if (s2_load) begin
      rsp_valid <= s1_v;
      if (s1_v) begin
        rsp_id   <= s1_id;
        rsp_data <= res;
        rsp_ov   <= ov;
      end
    end
  end

  // Saturating overflow counters; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else if (rsp_valid && rsp_ready && rsp_ov && (cnt[rsp_id] != '1)) begin
      cnt[rsp_id] <= cnt[rsp_id] + OVCNT_W'(1);
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    assign ov_cnt[i*OVCNT_W +: OVCNT_W] = cnt[i];
  end

endmodule

// File: tb/tb_satrnd_arbiter.sv
// Self-checking bench for satrnd_arbiter: table-driven arithmetic vectors,
// round-robin streaming, stall, counter saturation/clear and mid-run reset.
module tb_satrnd_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int MSB   = 14;
  localparam int LSB   = 4;
  localparam int OVW   = 2;
  localparam int OUTW  = MSB - LSB + 1;

  typedef struct packed {
    logic [1:0]  id;
    logic [10:0] data;
    logic        ov;
  } exp_t;

  typedef struct {
    int          id;
    logic [15:0] din;
    logic        tc;
    logic        sat;
    logic        rnd;
    logic [10:0] ed;
    logic        eov;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         req_tc;
  logic [NREQ-1:0]         req_sat;
  logic [NREQ-1:0]         req_rnd;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [1:0]              rsp_id;
  logic [OUTW-1:0]         rsp_data;
  logic                    rsp_ov;
  logic [NREQ*OVW-1:0]     ov_cnt;
  logic                    cnt_clr;

  satrnd_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .MSB_OUT(MSB), .LSB_OUT(LSB), .OVCNT_W(OVW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_tc(req_tc), .req_sat(req_sat), .req_rnd(req_rnd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ov(rsp_ov), .ov_cnt(ov_cnt), .cnt_clr(cnt_clr)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   glog[$];
  int   exp_cnt[NREQ];
  int   tb_ptr = 0;
  int   acc_cnt = 0;
  int   first_rdy = -1;
  int   first_rsp = -1;
  logic use_tab = 1'b0;
  exp_t tab_e;
  logic prev_v = 1'b0;
  logic prev_rdy = 1'b0;
  logic [1:0]  prev_id;
  logic [10:0] prev_data;
  logic        prev_ov;
  vec_t tab[13];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference reduction: shift, round, range check, saturate.
  function automatic exp_t model(input int id, input logic [15:0] d,
                                 input logic tc, input logic sat, input logic rnd);
    longint v, r;
    exp_t   e;
    v = longint'(d);
    if (tc && d[15]) v = v - 65536;
    r = v >>> LSB;
    if (rnd && d[LSB-1]) r = r + 1;
    if (tc) e.ov = (r < -(longint'(1) << (OUTW - 1))) || (r > (longint'(1) << (OUTW - 1)) - 1);
    else    e.ov = (r > (longint'(1) << OUTW) - 1);
    if (e.ov && sat) e.data = tc ? (d[15] ? 11'h400 : 11'h3FF) : 11'h7FF;
    else             e.data = r[10:0];
    e.id = 2'(id);
    return e;
  endfunction

  // Scoreboard monitor: predicts grants, pushes expectations, checks responses.
  always @(negedge clk) begin
    exp_t e;
    logic [NREQ-1:0] er;
    int g;
    if (!rst_n) begin
      sb.delete();
      for (int i = 0; i < NREQ; i++) exp_cnt[i] = 0;
      tb_ptr = 0;
      prev_v = 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) chk("ov_cnt", 64'(ov_cnt[i*OVW +: OVW]), 64'(exp_cnt[i]));
      if (prev_v && !prev_rdy) begin
        chk("stall_valid", 64'(rsp_valid), 64'd1);
        chk("stall_id", 64'(rsp_id), 64'(prev_id));
        chk("stall_data", 64'(rsp_data), 64'(prev_data));
        chk("stall_ov", 64'(rsp_ov), 64'(prev_ov));
      end
      er = '0;
      g  = -1;
      if (!(sb.size() == 2 && !rsp_ready))
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(tb_ptr + k) % NREQ]) g = (tb_ptr + k) % NREQ;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      if (rsp_valid && first_rsp < 0) first_rsp = cyc;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id %0d data %0h, expected no response", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_ov", 64'(rsp_ov), 64'(e.ov));
          if (e.ov && exp_cnt[e.id] < (1 << OVW) - 1) exp_cnt[e.id]++;
        end
      end
      if (cnt_clr) for (int i = 0; i < NREQ; i++) exp_cnt[i] = 0;
      if (g >= 0) begin
        if (use_tab) sb.push_back(tab_e);
        else sb.push_back(model(g, req_data[g*WIDTH +: WIDTH], req_tc[g], req_sat[g], req_rnd[g]));
        tb_ptr = (g + 1) % NREQ;
        acc_cnt++;
        glog.push_back(g);
        if (first_rdy < 0) first_rdy = cyc;
      end
      prev_v    = rsp_valid;
      prev_rdy  = rsp_ready;
      prev_id   = rsp_id;
      prev_data = rsp_data;
      prev_ov   = rsp_ov;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 30 && !done; k++) begin
      tick();
      if (sb.size() == 0 && !rsp_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
  endtask

  // Single-requester request with a table-supplied expectation.
  task automatic apply(input vec_t v);
    logic got;
    tab_e   = '{id: 2'(v.id), data: v.ed, ov: v.eov};
    use_tab = 1'b1;
    req_data[v.id*WIDTH +: WIDTH] = v.din;
    req_tc[v.id]  = v.tc;
    req_sat[v.id] = v.sat;
    req_rnd[v.id] = v.rnd;
    req_valid     = NREQ'(1) << v.id;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[v.id]) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no ready, expected ready on %0d", v.id);
    end
    tick();
    req_valid = '0;
    use_tab   = 1'b0;
  endtask

  initial begin
    int   rr_exp[5];
    vec_t ovv;
    logic seen;
    rr_exp = '{0, 1, 2, 3, 0};
    tab[0]  = '{0, 16'h3FF8, 1'b1, 1'b1, 1'b1, 11'h3FF, 1'b1};
    tab[1]  = '{1, 16'h8000, 1'b1, 1'b1, 1'b0, 11'h400, 1'b1};
    tab[2]  = '{1, 16'h8000, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1};
    tab[3]  = '{2, 16'h7FF0, 1'b0, 1'b0, 1'b1, 11'h7FF, 1'b0};
    tab[4]  = '{2, 16'h7FF0, 1'b1, 1'b1, 1'b1, 11'h3FF, 1'b1};
    tab[5]  = '{3, 16'h0128, 1'b1, 1'b0, 1'b1, 11'h013, 1'b0};
    tab[6]  = '{3, 16'hFFF8, 1'b1, 1'b1, 1'b1, 11'h000, 1'b0};
    tab[7]  = '{0, 16'hFFF8, 1'b0, 1'b1, 1'b1, 11'h7FF, 1'b1};
    tab[8]  = '{0, 16'hFFF8, 1'b0, 1'b0, 1'b1, 11'h000, 1'b1};
    tab[9]  = '{1, 16'hC000, 1'b1, 1'b0, 1'b0, 11'h400, 1'b0};
    tab[10] = '{1, 16'hBFF0, 1'b1, 1'b1, 1'b0, 11'h400, 1'b1};
    tab[11] = '{2, 16'h3FE8, 1'b1, 1'b1, 1'b0, 11'h3FE, 1'b0};
    tab[12] = '{3, 16'h3FE8, 1'b0, 1'b0, 1'b1, 11'h3FF, 1'b0};

    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    cnt_clr   = 1'b0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*WIDTH +: WIDTH] = 16'($urandom);
      req_tc[i]  = 1'($urandom);
      req_sat[i] = 1'($urandom);
      req_rnd[i] = 1'($urandom);
    end
    req_valid = '1;

    // Reset state, with requests pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_ov", 64'(rsp_ov), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_ov_cnt", 64'(ov_cnt), 64'd0);
    tick();
    rst_n = 1'b1;

    // All requesters valid: strict rotation and two-cycle latency.
    repeat (8) tick();
    drain();
    if (glog.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", 64'(glog[i]), 64'(rr_exp[i]));
    end else begin
      checks++;
      errors++;
      $display("FAIL rr_count: got %0d grants, expected at least 5", glog.size());
    end
    chk("latency", 64'(first_rsp - first_rdy), 64'd2);

    // Arithmetic vectors.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    apply(tab[0]);
    drain();
    chk("ov_cnt0_vec0", 64'(ov_cnt[1:0]), 64'd1);
    for (int i = 1; i < 13; i++) apply(tab[i]);
    drain();

    // Counter saturation with back-to-back wins by one requester.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    ovv = '{3, 16'hFFF8, 1'b0, 1'b1, 1'b1, 11'h7FF, 1'b1};
    repeat (4) apply(ovv);
    drain();
    chk("ov_cnt3_sat", 64'(ov_cnt[7:6]), 64'd3);

    // Clear coinciding with an overflow handshake.
    apply(ovv);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (rsp_valid) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL clr_wait: got no rsp_valid, expected one");
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("ov_cnt3_clr", 64'(ov_cnt[7:6]), 64'd0);
    drain();

    // Downstream stall with everybody requesting.
    rsp_ready = 1'b0;
    acc_cnt   = 0;
    req_valid = '1;
    repeat (5) tick();
    chk("stall_accepts", 64'(acc_cnt), 64'd2);
    rsp_ready = 1'b1;
    repeat (6) tick();
    drain();

    // Reset in the middle of traffic discards in-flight results.
    req_valid = '1;
    repeat (3) tick();
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_ov_cnt", 64'(ov_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("midrst_rsp_valid_after", 64'(rsp_valid), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
